cube_sort16: RTL and testbench



---
 rtl/cube_sort16.sv | 164 ++++++++++++++++
 tb/tb_cube_sort16.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cube_sort16.sv
// 16-lane bitonic (hypercube) sorting network, 10 registered compare-exchange stages.
// Define CUBE_SORT_DESC_EN to invert the final merge so dout0 carries the maximum.
module cube_sort16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    input  logic [WIDTH-1:0] din4,
    input  logic [WIDTH-1:0] din5,
    input  logic [WIDTH-1:0] din6,
    input  logic [WIDTH-1:0] din7,
    input  logic [WIDTH-1:0] din8,
    input  logic [WIDTH-1:0] din9,
    input  logic [WIDTH-1:0] din10,
    input  logic [WIDTH-1:0] din11,
    input  logic [WIDTH-1:0] din12,
    input  logic [WIDTH-1:0] din13,
    input  logic [WIDTH-1:0] din14,
    input  logic [WIDTH-1:0] din15,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic [WIDTH-1:0] dout4,
    output logic [WIDTH-1:0] dout5,
    output logic [WIDTH-1:0] dout6,
    output logic [WIDTH-1:0] dout7,
    output logic [WIDTH-1:0] dout8,
    output logic [WIDTH-1:0] dout9,
    output logic [WIDTH-1:0] dout10,
    output logic [WIDTH-1:0] dout11,
    output logic [WIDTH-1:0] dout12,
    output logic [WIDTH-1:0] dout13,
    output logic [WIDTH-1:0] dout14,
    output logic [WIDTH-1:0] dout15
);

    localparam int unsigned LANES  = 16;
    localparam int unsigned STAGES = 10;

`ifdef CUBE_SORT_DESC_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    // Stage s walks i = 1..4 and, within each i, j = i-1 down to 0.
    function automatic int unsigned stage_i(input int unsigned s);
        if (s == 0)      return 1;
        else if (s < 3)  return 2;
        else if (s < 6)  return 3;
        else             return 4;
    endfunction

    function automatic int unsigned stage_j(input int unsigned s);
        case (s)
            0:       return 0;
            1:       return 1;
            2:       return 0;
            3:       return 2;
            4:       return 1;
            5:       return 0;
            6:       return 3;
            7:       return 2;
            8:       return 1;
            default: return 0;
        endcase
    endfunction

    logic [WIDTH-1:0] din_a  [LANES];
    logic [WIDTH-1:0] src    [STAGES][LANES];
    logic [WIDTH-1:0] data_d [STAGES][LANES];
    logic [WIDTH-1:0] data_q [STAGES][LANES];
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] vld_q;

    assign din_a[0]  = din0;
    assign din_a[1]  = din1;
    assign din_a[2]  = din2;
    assign din_a[3]  = din3;
    assign din_a[4]  = din4;
    assign din_a[5]  = din5;
    assign din_a[6]  = din6;
    assign din_a[7]  = din7;
    assign din_a[8]  = din8;
    assign din_a[9]  = din9;
    assign din_a[10] = din10;
    assign din_a[11] = din11;
    assign din_a[12] = din12;
    assign din_a[13] = din13;
    assign din_a[14] = din14;
    assign din_a[15] = din15;

    genvar s, k;
    generate
        for (s = 0; s < STAGES; s++) begin : g_stage
            for (k = 0; k < LANES; k++) begin : g_lane
                localparam int unsigned I = stage_i(s);
                localparam int unsigned J = stage_j(s);
                localparam int unsigned P = k ^ (1 << J);
                localparam bit ASC = (((k >> I) & 1) == 0) ^ (DESC && (I == 4));
                // The lower lane of an ascending pair (or upper lane of a descending one) keeps the min.
                localparam bit KEEP_MIN = (ASC == (k < P));

                if (s == 0) begin : g_first
                    assign src[s][k] = din_a[k];
                end else begin : g_next
                    assign src[s][k] = data_q[s-1][k];
                end

                if (KEEP_MIN) begin : g_min
                    assign data_d[s][k] = (src[s][k] <= src[s][P]) ? src[s][k] : src[s][P];
                end else begin : g_max
                    assign data_d[s][k] = (src[s][k] >= src[s][P]) ? src[s][k] : src[s][P];
                end
            end
        end
    endgenerate

    assign vld_d = {vld_q[STAGES-2:0], in_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned st = 0; st < STAGES; st++) begin
                for (int unsigned ln = 0; ln < LANES; ln++) begin
                    data_q[st][ln] <= '0;
                end
            end
            vld_q <= '0;
        end else begin
            for (int unsigned st = 0; st < STAGES; st++) begin
                for (int unsigned ln = 0; ln < LANES; ln++) begin
                    data_q[st][ln] <= data_d[st][ln];
                end
            end
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign dout0  = data_q[STAGES-1][0];
    assign dout1  = data_q[STAGES-1][1];
    assign dout2  = data_q[STAGES-1][2];
    assign dout3  = data_q[STAGES-1][3];
    assign dout4  = data_q[STAGES-1][4];
    assign dout5  = data_q[STAGES-1][5];
    assign dout6  = data_q[STAGES-1][6];
    assign dout7  = data_q[STAGES-1][7];
    assign dout8  = data_q[STAGES-1][8];
    assign dout9  = data_q[STAGES-1][9];
    assign dout10 = data_q[STAGES-1][10];
    assign dout11 = data_q[STAGES-1][11];
    assign dout12 = data_q[STAGES-1][12];
    assign dout13 = data_q[STAGES-1][13];
    assign dout14 = data_q[STAGES-1][14];
    assign dout15 = data_q[STAGES-1][15];

endmodule

// File: tb/tb_cube_sort16.sv
// Bench for cube_sort16: directed and random vectors checked against a sort-based reference.
module tb_cube_sort16;

    localparam int unsigned W = 16;
    typedef logic [W-1:0] vec_t [16];
    typedef struct {
        bit           v;
        logic [255:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    vec_t din;
    logic out_valid;
    vec_t dout;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned n_chk  = 0;
    ent_t hist[$];

    always #5 clk = ~clk;

    cube_sort16 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .din0(din[0]),   .din1(din[1]),   .din2(din[2]),   .din3(din[3]),
        .din4(din[4]),   .din5(din[5]),   .din6(din[6]),   .din7(din[7]),
        .din8(din[8]),   .din9(din[9]),   .din10(din[10]), .din11(din[11]),
        .din12(din[12]), .din13(din[13]), .din14(din[14]), .din15(din[15]),
        .out_valid(out_valid),
        .dout0(dout[0]),   .dout1(dout[1]),   .dout2(dout[2]),   .dout3(dout[3]),
        .dout4(dout[4]),   .dout5(dout[5]),   .dout6(dout[6]),   .dout7(dout[7]),
        .dout8(dout[8]),   .dout9(dout[9]),   .dout10(dout[10]), .dout11(dout[11]),
        .dout12(dout[12]), .dout13(dout[13]), .dout14(dout[14]), .dout15(dout[15])
    );

    function automatic logic [255:0] pack(input vec_t v);
        logic [255:0] r = '0;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = v[i];
        return r;
    endfunction

    function automatic logic [255:0] ref_sort(input vec_t v);
        int q[$];
        logic [255:0] r = '0;
        for (int i = 0; i < 16; i++) q.push_back(int'(v[i]));
        q.sort();
`ifdef CUBE_SORT_DESC_EN
        q.reverse();
`endif
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = q[i][15:0];
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit v, input vec_t vec);
        ent_t e;
        @(negedge clk);
        in_valid = v;
        din = vec;
        @(posedge clk);
        if (v) n_vec++;
        e.v = v;
        e.d = ref_sort(vec);
        hist.push_back(e);
        #1;
        if (hist.size() == 10) begin
            e = hist.pop_front();
            check("out_valid", {255'd0, out_valid}, {255'd0, e.v});
            if (e.v) check("dout", pack(dout), e.d);
        end else begin
            check("out_valid_fill", {255'd0, out_valid}, '0);
        end
    endtask

    task automatic rand_vec(output vec_t v);
        int unsigned mode = $urandom_range(0, 3);
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0:       v[i] = W'($urandom_range(0, 7));
                1:       v[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
                default: v[i] = W'($urandom);
            endcase
        end
    endtask

    task automatic idle(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            rand_vec(v);
            step(1'b0, v);
        end
    endtask

    initial begin : main
        vec_t v, v2, v3;
        logic [255:0] exp_c;

        // Reset state
        rst = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) din[i] = '0;
        #12;
        check("rst_out_valid", {255'd0, out_valid}, '0);
        check("rst_dout", pack(dout), '0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: mixed vector, also checked against literal result
        v = '{16'd3, 16'd5, 16'd8, 16'd9, 16'd10, 16'd12, 16'd14, 16'd20,
              16'd95, 16'd90, 16'd60, 16'd40, 16'd35, 16'd32, 16'd18, 16'd0};
`ifdef CUBE_SORT_DESC_EN
        v2 = '{16'd95, 16'd90, 16'd60, 16'd40, 16'd35, 16'd32, 16'd20, 16'd18,
               16'd14, 16'd12, 16'd10, 16'd9, 16'd8, 16'd5, 16'd3, 16'd0};
`else
        v2 = '{16'd0, 16'd3, 16'd5, 16'd8, 16'd9, 16'd10, 16'd12, 16'd14,
               16'd18, 16'd20, 16'd32, 16'd35, 16'd40, 16'd60, 16'd90, 16'd95};
`endif
        step(1'b1, v);
        idle(9);
        check("t1_literal", pack(dout), pack(v2));
        check("t1_valid", {255'd0, out_valid}, 256'd1);
        idle(1);
        check("t1_one_cycle", {255'd0, out_valid}, '0);

        // Test 2: all-ones with a single zero
        for (int i = 0; i < 16; i++) v[i] = 16'hFFFF;
        v[7] = 16'h0000;
        step(1'b1, v);
        idle(9);
`ifdef CUBE_SORT_DESC_EN
        exp_c = {16'h0000, {15{16'hFFFF}}};
`else
        exp_c = {{15{16'hFFFF}}, 16'h0000};
`endif
        check("t2_literal", pack(dout), exp_c);

        // Test 3: duplicated pairs
        for (int i = 0; i < 16; i++) v[i] = (i % 4 < 2) ? 16'd7 : 16'd1;
        step(1'b1, v);
        idle(9);

        // Test 4: three back-to-back vectors
        for (int i = 0; i < 16; i++) begin
            v[i]  = W'(i * 3 + 1);
            v2[i] = W'(1000 - i * 7);
            v3[i] = 16'd42;
        end
        step(1'b1, v);
        step(1'b1, v2);
        step(1'b1, v3);
        idle(10);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            rand_vec(v);
            step($urandom_range(0, 3) != 0, v);
        end
        idle(10);

        // Reset with two vectors in flight
        rand_vec(v);
        step(1'b1, v);
        rand_vec(v);
        step(1'b1, v);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", {255'd0, out_valid}, '0);
        check("midrst_dout", pack(dout), '0);
        hist.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(15);

        // Traffic after reset release
        for (int n = 0; n < 40; n++) begin
            rand_vec(v);
            step($urandom_range(0, 1) != 0, v);
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
